// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the fetch stage and the decode controller:
//   - NOP_INSTR_DEFAULT : bubble word (addi x0,x0,0) placed in IF/ID
//   - OPC_*             : major opcode constants for R/I/S/L/B/MAC classes
//   - fetch_state_e     : instruction fetch FSM state encoding
package mips_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Major opcode field (instr[6:0]) per instruction class
    localparam logic [6:0] OPC_R_TYPE = 7'b011_0011;
    localparam logic [6:0] OPC_I_TYPE = 7'b001_0011;
    localparam logic [6:0] OPC_S_TYPE = 7'b010_0011;
    localparam logic [6:0] OPC_L_TYPE = 7'b000_0011;
    localparam logic [6:0] OPC_B_TYPE = 7'b110_0011;
    localparam logic [6:0] OPC_MAC    = 7'b000_1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer
// One-entry holding register for an instruction word that arrived while
// the pipeline was stalled.
// Ports:
//   clk      in   clock
//   rst      in   async active-high reset (entry invalid)
//   i_load   in   capture i_data, mark entry valid
//   i_clear  in   invalidate entry (wins over i_load)
//   i_data   in   word to capture
//   o_data   out  stored word
//   o_valid  out  entry holds a word
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_valid
);

    logic [31:0] r_data;
    logic        r_valid;

    // Storage register; clear has priority so a redirect always empties the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else begin
            r_data  <= r_data;
            r_valid <= r_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
// Fetches instruction words from instruction memory and presents them in
// the IF/ID pipeline register. Handles memory wait states (bubbles),
// hazard stalls (response parked in a skid buffer) and branch redirects.
// Ports:
//   clk, rst            clock, async active-high reset
//   stall               freeze PC and IF/ID
//   branch_taken        one-cycle redirect strobe, overrides everything
//   branch_target       redirect address (low two bits ignored)
//   imem_req/imem_addr  read request / word-aligned address
//   imem_ready          imem_rdata valid for imem_addr this cycle
//   imem_rdata          instruction word
//   IF_ID_instruction   registered instruction (NOP_INSTR for a bubble)
//   IF_ID_pc            registered PC of IF_ID_instruction
//   IF_ID_valid         IF_ID_instruction is a real fetched word
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_valid
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic        r_ifid_valid;
    logic        r_imem_req;

    logic [31:0] w_pc_next;
    logic [31:0] w_ifid_instr_next;
    logic [31:0] w_ifid_pc_next;
    logic        w_ifid_valid_next;
    logic        w_skid_load;
    logic        w_skid_clear;
    logic [31:0] w_skid_data;
    logic        w_skid_valid;
    logic [31:0] w_target_aligned;

    assign w_target_aligned = branch_target & 32'hFFFF_FFFC;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (imem_rdata),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid)
    );

    // Next-state and datapath decisions; a redirect overrides stall and state
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_valid_next = r_ifid_valid;
        w_skid_load       = 1'b0;
        w_skid_clear      = 1'b0;

        if (branch_taken) begin
            // Any same-cycle memory response is dropped; IF_ID_pc keeps its last value
            w_pc_next         = w_target_aligned;
            w_ifid_instr_next = NOP_INSTR;
            w_ifid_valid_next = 1'b0;
            w_skid_clear      = 1'b1;
            w_state_next      = ST_FETCH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            // Park the word so it is neither lost nor duplicated
                            w_skid_load  = 1'b1;
                            w_state_next = ST_HOLD;
                        end else begin
                            w_ifid_instr_next = imem_rdata;
                            w_ifid_pc_next    = r_pc;
                            w_ifid_valid_next = 1'b1;
                            w_pc_next         = r_pc + 32'd4;
                            w_state_next      = ST_FETCH;
                        end
                    end else begin
                        if (stall) begin
                            w_state_next = ST_FETCH;
                        end else begin
                            w_ifid_instr_next = NOP_INSTR;
                            w_ifid_valid_next = 1'b0;
                            w_state_next      = ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (stall) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_ifid_instr_next = w_skid_data;
                        w_ifid_pc_next    = r_pc;
                        w_ifid_valid_next = 1'b1;
                        w_pc_next         = r_pc + 32'd4;
                        w_skid_clear      = 1'b1;
                        w_state_next      = ST_FETCH;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, PC, IF/ID and request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC & 32'hFFFF_FFFC;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
            r_imem_req   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_valid <= w_ifid_valid_next;
            r_imem_req   <= (w_state_next == ST_FETCH);
        end
    end

    assign imem_req          = r_imem_req;
    assign imem_addr         = r_pc;
    assign IF_ID_instruction = r_ifid_instr;
    assign IF_ID_pc          = r_ifid_pc;
    assign IF_ID_valid       = r_ifid_valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;

    int checks;
    int failures;

    instruction_fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_pc          (IF_ID_pc),
        .IF_ID_valid       (IF_ID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Memory contents: mem[0] is the given R-type word, elsewhere address ^ 0x55000000
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0020_8033;
        else return a ^ 32'h5500_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] instr, input logic [31:0] ipc, input logic vld);
        chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
        chk({tag, ".addr"},  imem_addr,            addr);
        chk({tag, ".instr"}, IF_ID_instruction,    instr);
        chk({tag, ".pc"},    IF_ID_pc,             ipc);
        chk({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, vld});
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic r,
                                input logic q, input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] p, input logic v);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.ready = r;
        x.req = q; x.addr = a; x.instr = i; x.ipc = p; x.valid = v;
        return x;
    endfunction

    // Apply one cycle of inputs, memory answers for the current address
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_ready    = r;
        imem_rdata    = word_at(imem_addr);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[19];

    initial begin
        checks   = 0;
        failures = 0;

        // Expected values are post-edge outputs
        //             stall br  tgt           rdy  req addr          instr         ifid_pc       valid
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0000, NOP,          32'h0,        1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0004, 32'h0020_8033, 32'h0,       1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0008, 32'h5500_0004, 32'h4,       1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0008, NOP,          32'h4,        1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0008, NOP,          32'h4,        1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0008, NOP,          32'h4,        1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_000C, 32'h5500_0008, 32'h8,       1'b1);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_000C, 32'h5500_0008, 32'h8,       1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_000C, 32'h5500_0008, 32'h8,       1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0010, 32'h5500_000C, 32'hC,       1'b1);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0014, 32'h5500_0010, 32'h10,      1'b1);
        vecs[11] = mk(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0014, 32'h5500_0010, 32'h10,      1'b1);
        vecs[12] = mk(1'b1, 1'b1, 32'h103,     1'b1, 1'b1, 32'h0000_0100, NOP,          32'h10,       1'b0);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0100, NOP,          32'h10,       1'b0);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0104, 32'h5500_0100, 32'h100,     1'b1);
        vecs[15] = mk(1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0104, 32'h5500_0100, 32'h100,     1'b1);
        vecs[16] = mk(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFC, NOP,        32'h100,      1'b0);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0000, 32'hAAFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0004, 32'h0020_8033, 32'h0,       1'b1);

        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({"idle.req"}, {31'd0, imem_req}, 32'd0);

        for (int k = 0; k < 19; k++) begin
            step(vecs[k].stall, vecs[k].br, vecs[k].tgt, vecs[k].ready);
            chk_all($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr,
                    vecs[k].instr, vecs[k].ipc, vecs[k].valid);
        end

        // Reset pulse during HOLD: pending word must be discarded
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk_all("hold_pre", 1'b0, 32'h4, 32'h0020_8033, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        chk_all("rst_async", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk({"rst_idle.req"}, {31'd0, imem_req}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("rst_first_req", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("rst_first_word", 1'b1, 32'h4, 32'h0020_8033, 32'h0, 1'b1);

        // Redirect while in IDLE still enters FETCH at the new address
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        step(1'b0, 1'b1, 32'h0000_0207, 1'b1);
        chk_all("idle_branch", 1'b1, 32'h204, NOP, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("idle_branch_word", 1'b1, 32'h208, 32'h5500_0204, 32'h204, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
